// File: rtl/cls_pwm_channel_bank.sv
// cls_pwm_channel_bank: bank of tick-driven PWM channels with double-buffered duty,
// per-channel enable/inversion and optional phase staggering.
module cls_pwm_channel_bank #(
  parameter int CHANNELS = 8,
  parameter int PERIOD_TICKS = 100,
  parameter int DUTY_WIDTH = 7,
  parameter int PHASE_STAGGER = 0,
  parameter logic [CHANNELS-1:0] OUT_INVERT = '0,
  localparam int CH_W = $clog2(CHANNELS) + 1,
  localparam int CNT_W = $clog2(PERIOD_TICKS)
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  PWM_INTERVAL_TICK,
  input  logic [CHANNELS-1:0]   CH_ENABLE,
  input  logic                  DUTY_WR_EN,
  input  logic [CH_W-1:0]       DUTY_WR_CH,
  input  logic [DUTY_WIDTH-1:0] DUTY_WR_VAL,
  output logic                  DUTY_WR_ERR,
  output logic [CHANNELS-1:0]   UPDATE_PENDING,
  output logic                  PERIOD_START,
  output logic [CHANNELS-1:0]   PWM_OUT
);
  localparam int PW = CNT_W + 1;
  localparam int STEP = PHASE_STAGGER != 0 ? PERIOD_TICKS / CHANNELS : 0;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CHANNELS-1:0][DUTY_WIDTH-1:0] act_q, act_d, sh_q, sh_d;
  logic [CHANNELS-1:0] pend_q, pend_d, pwm_q, pwm_d;
  logic err_q, err_d, ps_q, ps_d;
  logic wrap, wr_ok;
  logic [PW-1:0] ph;
  always_comb begin
    wrap = PWM_INTERVAL_TICK && cnt_q == CNT_W'(PERIOD_TICKS - 1);
    wr_ok = DUTY_WR_EN && DUTY_WR_CH < CH_W'(CHANNELS);
    cnt_d = wrap ? '0 : cnt_q + CNT_W'(PWM_INTERVAL_TICK);
    ps_d = wrap;
    err_d = DUTY_WR_EN && !wr_ok;
    act_d = act_q;
    sh_d = sh_q;
    pend_d = pend_q;
    pwm_d = '0;
    ph = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      // boundary consumes the old shadow; a same-edge write re-arms pending
      if (wrap && pend_q[i]) begin
        act_d[i] = sh_q[i];
        pend_d[i] = 1'b0;
      end
      if (wr_ok && DUTY_WR_CH == CH_W'(i)) begin
        sh_d[i] = DUTY_WR_VAL;
        pend_d[i] = 1'b1;
      end
      ph = {1'b0, cnt_q} + PW'(i * STEP);
      ph = ph >= PW'(PERIOD_TICKS) ? ph - PW'(PERIOD_TICKS) : ph;
      pwm_d[i] = CH_ENABLE[i] & (({{DUTY_WIDTH{1'b0}}, ph} < {{PW{1'b0}}, act_q[i]}) ^ OUT_INVERT[i]);
    end
  end
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q <= '0;
      act_q <= '0;
      sh_q <= '0;
      pend_q <= '0;
      pwm_q <= '0;
      err_q <= 1'b0;
      ps_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      act_q <= act_d;
      sh_q <= sh_d;
      pend_q <= pend_d;
      pwm_q <= pwm_d;
      err_q <= err_d;
      ps_q <= ps_d;
    end
  end
  assign DUTY_WR_ERR = err_q;
  assign UPDATE_PENDING = pend_q;
  assign PERIOD_START = ps_q;
  assign PWM_OUT = pwm_q;
endmodule
